// File: rtl/joy_db15_tx.sv
// Adapter-side DB15 joystick shifter: captures two player words on joy_load and shifts them out on joy_clk.
// Optional macro JOY_DB15_TX_GLITCH_FILTER_EN adds a 3-cycle level filter on the synchronised strobes.
module joy_db15_tx #(
  parameter int   BITS_PER_PLAYER = 16,
  parameter int   SYNC_STAGES     = 2,
  parameter logic FILL_BIT        = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [BITS_PER_PLAYER-1:0] joy_1,
  input  logic [BITS_PER_PLAYER-1:0] joy_2,
  input  logic                       joy_load,
  input  logic                       joy_clk,
  output logic                       joy_data,
  output logic                       busy,
  output logic                       frame_done,
  output logic [5:0]                 bit_count
);

  localparam int         W         = 2 * BITS_PER_PLAYER;
  localparam logic [5:0] FRAME_LEN = 6'(W);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t           state, state_next;
  logic [W-1:0]     sr, sr_next, load_value;
  logic [5:0]       bit_count_next;
  logic             busy_next, frame_done_next, joy_data_next;
  logic [SYNC_STAGES-1:0] clk_sync, load_sync;
  logic             clk_lvl, load_lvl, clk_d, load_d;
  logic             clk_rise, load_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      load_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], joy_clk};
      load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load};
    end
  end

`ifdef JOY_DB15_TX_GLITCH_FILTER_EN
  // A new level is accepted in the third consecutive cycle it is seen, so pulses of 2 cycles never pass.
  logic [1:0] clk_hist, load_hist;
  logic       clk_filt, load_filt;

  always_comb begin
    clk_lvl  = clk_filt;
    load_lvl = load_filt;
    if (clk_sync[SYNC_STAGES-1] == clk_hist[0] && clk_hist[0] == clk_hist[1])
      clk_lvl = clk_sync[SYNC_STAGES-1];
    if (load_sync[SYNC_STAGES-1] == load_hist[0] && load_hist[0] == load_hist[1])
      load_lvl = load_sync[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_hist  <= '1;
      load_hist <= '1;
      clk_filt  <= 1'b1;
      load_filt <= 1'b1;
    end else begin
      clk_hist  <= {clk_hist[0], clk_sync[SYNC_STAGES-1]};
      load_hist <= {load_hist[0], load_sync[SYNC_STAGES-1]};
      clk_filt  <= clk_lvl;
      load_filt <= load_lvl;
    end
  end
`else
  assign clk_lvl  = clk_sync[SYNC_STAGES-1];
  assign load_lvl = load_sync[SYNC_STAGES-1];
`endif

  assign clk_rise  = clk_lvl & ~clk_d;
  assign load_rise = load_lvl & ~load_d;

  // Player 1 bit 0 lands in the MSB so it is the first bit on the line; buttons are inverted to active-low.
  always_comb begin
    load_value = '0;
    for (int i = 0; i < BITS_PER_PLAYER; i++) begin
      load_value[W-1-i]               = ~joy_1[i];
      load_value[BITS_PER_PLAYER-1-i] = ~joy_2[i];
    end
  end

  always_comb begin
    state_next      = state;
    sr_next         = sr;
    bit_count_next  = bit_count;
    busy_next       = busy;
    frame_done_next = 1'b0;
    joy_data_next   = (state == IDLE) ? FILL_BIT : sr[W-1];
    if (!load_lvl) begin
      state_next     = LOAD;
      sr_next        = load_value;
      bit_count_next = '0;
      busy_next      = 1'b1;
    end else begin
      case (state)
        LOAD: begin
          if (load_rise)
            state_next = SHIFT;
        end
        SHIFT: begin
          if (bit_count == FRAME_LEN) begin
            state_next      = IDLE;
            busy_next       = 1'b0;
            frame_done_next = 1'b1;
          end else if (clk_rise) begin
            sr_next        = {sr[W-2:0], FILL_BIT};
            bit_count_next = bit_count + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= {W{FILL_BIT}};
      bit_count  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      joy_data   <= FILL_BIT;
      clk_d      <= 1'b1;
      load_d     <= 1'b1;
    end else begin
      state      <= state_next;
      sr         <= sr_next;
      bit_count  <= bit_count_next;
      busy       <= busy_next;
      frame_done <= frame_done_next;
      joy_data   <= joy_data_next;
      clk_d      <= clk_lvl;
      load_d     <= load_lvl;
    end
  end

endmodule

// File: tb/tb_joy_db15_tx.sv
// Randomised self-checking bench for joy_db15_tx; expected serial bits come from the button words directly.
module tb_joy_db15_tx;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] joy_1 = '0;
  logic [N-1:0] joy_2 = '0;
  logic         joy_load = 1'b1;
  logic         joy_clk = 1'b0;
  logic         joy_data, busy, frame_done;
  logic [5:0]   bit_count;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int shifted = 0;
  int done_ref = 0;
  logic [N-1:0] cap1, cap2, p1, p2;

  joy_db15_tx dut (
    .clk(clk), .reset(reset), .joy_1(joy_1), .joy_2(joy_2),
    .joy_load(joy_load), .joy_clk(joy_clk), .joy_data(joy_data),
    .busy(busy), .frame_done(frame_done), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  // Line bit k of a frame: player 1 bits first (LSB first), then player 2, inverted; idle fill after.
  function automatic logic exp_bit(input logic [N-1:0] a, input logic [N-1:0] b, input int k);
    if (k < N) return ~a[k];
    if (k < 2 * N) return ~b[k-N];
    return 1'b1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic load, input logic sclk, input int cycles);
    joy_load = load;
    joy_clk  = sclk;
    tick(cycles);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic start_frame(input logic [N-1:0] a, input logic [N-1:0] b);
    joy_1 = a;
    joy_2 = b;
    applyStimulus(1'b0, 1'b0, 8);
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("load_count", 32'(bit_count), 32'd0);
    checkOutput("load_bit0", 32'(joy_data), 32'(exp_bit(a, b, 0)));
    cap1 = a;
    cap2 = b;
    shifted = 0;
    applyStimulus(1'b1, 1'b0, 8);
    checkOutput("armed_bit0", 32'(joy_data), 32'(exp_bit(a, b, 0)));
  endtask

  task automatic shift_n(input int n, input int scramble_at);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b1, 8);
      shifted++;
      applyStimulus(1'b1, 1'b0, 8);
      checkOutput("shift_count", 32'(bit_count), 32'(shifted));
      checkOutput("shift_data", 32'(joy_data), 32'(exp_bit(cap1, cap2, shifted)));
      if (shifted == scramble_at) begin
        joy_1 = N'($urandom);
        joy_2 = N'($urandom);
      end
    end
  endtask

  task automatic check_frame_end(input int done_before);
    checkOutput("frame_done_once", 32'(done_cnt), 32'(done_before + 1));
    checkOutput("end_busy", 32'(busy), 32'd0);
    checkOutput("end_count", 32'(bit_count), 32'd32);
    checkOutput("end_data", 32'(joy_data), 32'd1);
  endtask

  initial begin
    tick(4);
    checkOutput("rst_data", 32'(joy_data), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);
    checkOutput("rst_count", 32'(bit_count), 32'd0);
    reset = 1'b0;
    tick(1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 4);
      applyStimulus(1'b1, 1'b0, 4);
    end
    checkOutput("idle_data", 32'(joy_data), 32'd1);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_count", 32'(bit_count), 32'd0);
    checkOutput("idle_nodone", 32'(done_cnt), 32'd0);

    done_ref = done_cnt;
    start_frame(16'h0005, 16'h8000);
    shift_n(32, 3);
    check_frame_end(done_ref);

    repeat (3) begin
      done_ref = done_cnt;
      start_frame(N'($urandom), N'($urandom));
      shift_n(32, int'($urandom_range(1, 30)));
      check_frame_end(done_ref);
    end

    done_ref = done_cnt;
    start_frame(16'h0001, N'($urandom));
    shift_n(3, 0);
    joy_1 = 16'hFFFF;
    shift_n(29, 0);
    check_frame_end(done_ref);

    done_ref = done_cnt;
    start_frame(N'($urandom), N'($urandom));
    shift_n(10, 0);
    start_frame(N'($urandom), N'($urandom));
    checkOutput("abort_nodone", 32'(done_cnt), 32'(done_ref));
    shift_n(32, 0);
    check_frame_end(done_ref);

    done_ref = done_cnt;
    p1 = N'($urandom);
    p2 = N'($urandom);
    joy_1 = p1;
    joy_2 = p2;
    applyStimulus(1'b0, 1'b1, 8);
    checkOutput("simul_fall_count", 32'(bit_count), 32'd0);
    checkOutput("simul_fall_data", 32'(joy_data), 32'(exp_bit(p1, p2, 0)));
    applyStimulus(1'b0, 1'b0, 8);
    applyStimulus(1'b1, 1'b1, 8);
    checkOutput("simul_rise_count", 32'(bit_count), 32'd0);
    checkOutput("simul_rise_data", 32'(joy_data), 32'(exp_bit(p1, p2, 0)));
    applyStimulus(1'b1, 1'b0, 8);
    cap1 = p1;
    cap2 = p2;
    shifted = 0;
    shift_n(32, 0);
    check_frame_end(done_ref);

    done_ref = done_cnt;
    start_frame(N'($urandom), N'($urandom));
    shift_n(2, 0);
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b1, 1'b0, 14);
`ifndef JOY_DB15_TX_GLITCH_FILTER_EN
    shifted++;
`endif
    checkOutput("short_pulse_count", 32'(bit_count), 32'(shifted));
    checkOutput("short_pulse_data", 32'(joy_data), 32'(exp_bit(cap1, cap2, shifted)));
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b1, 1'b0, 12);
    shifted++;
    checkOutput("long_pulse_count", 32'(bit_count), 32'(shifted));
    checkOutput("long_pulse_data", 32'(joy_data), 32'(exp_bit(cap1, cap2, shifted)));
    shift_n(32 - shifted, 0);
    check_frame_end(done_ref);

    start_frame(N'($urandom), N'($urandom));
    shift_n(5, 0);
    reset = 1'b1;
    tick(1);
    checkOutput("midrst_data", 32'(joy_data), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(frame_done), 32'd0);
    checkOutput("midrst_count", 32'(bit_count), 32'd0);
    reset = 1'b0;
    done_ref = done_cnt;
    applyStimulus(1'b1, 1'b1, 8);
    applyStimulus(1'b1, 1'b0, 8);
    checkOutput("postrst_nodone", 32'(done_cnt), 32'(done_ref));
    checkOutput("postrst_count", 32'(bit_count), 32'd0);
    checkOutput("postrst_data", 32'(joy_data), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
